// File: rtl/full_handshake_tx_arb.sv
// TX-side round-robin scheduler for a four-phase req/ack CDC link.
// Picks one pending requester, drives req/data, waits for the synchronised ack, pulses done.
module full_handshake_tx_arb #(
    parameter int unsigned NUM = 4,
    parameter int unsigned DW  = 32,
    localparam int unsigned IW = (NUM > 1) ? $clog2(NUM) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM-1:0]      req_valid_i,
    input  logic [NUM*DW-1:0]   req_data_i,
    output logic [NUM-1:0]      done_o,
    output logic [IW-1:0]       grant_idx_o,
    output logic                busy_o,
    output logic                req_o,
    output logic [DW-1:0]       req_data_o,
    input  logic                ack_i
);

    typedef enum logic [1:0] {
        StIdle     = 2'b00,
        StAssert   = 2'b01,
        StDeassert = 2'b10
    } state_e;

    state_e         state_q, state_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [IW-1:0]  ptr_q, ptr_d;
    logic           req_q, req_d;
    logic [DW-1:0]  data_q, data_d;
    logic [NUM-1:0] done_q, done_d;
    logic           ack_meta_q, ack_s_q;

    logic           pick_found;
    logic [IW-1:0]  pick_idx;
    logic [DW-1:0]  data_arr [NUM];

    for (genvar g = 0; g < NUM; g++) begin : g_data
        assign data_arr[g] = req_data_i[g*DW +: DW];
    end

    // ack_i is asynchronous to clk; only ack_s_q may be used downstream.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_meta_q <= 1'b0;
            ack_s_q    <= 1'b0;
        end else begin
            ack_meta_q <= ack_i;
            ack_s_q    <= ack_meta_q;
        end
    end

    // First pending requester at or after the rr pointer, wrapping modulo NUM.
    always_comb begin
        int unsigned   cand;
        logic [IW-1:0] cand_idx;
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        cand_idx   = '0;
        for (int unsigned i = 0; i < NUM; i++) begin
            cand = 32'(ptr_q) + i;
            if (cand >= NUM) begin
                cand = cand - NUM;
            end
            cand_idx = IW'(cand);
            if (!pick_found && req_valid_i[cand_idx]) begin
                pick_found = 1'b1;
                pick_idx   = cand_idx;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q  <= '0;
            ptr_q  <= '0;
            req_q  <= 1'b0;
            data_q <= '0;
            done_q <= '0;
        end else begin
            idx_q  <= idx_d;
            ptr_q  <= ptr_d;
            req_q  <= req_d;
            data_q <= data_d;
            done_q <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        req_d   = req_q;
        data_d  = data_q;
        done_d  = '0;
        case (state_q)
            StIdle: begin
                req_d = 1'b0;
                if (pick_found) begin
                    idx_d   = pick_idx;
                    data_d  = data_arr[pick_idx];
                    req_d   = 1'b1;
                    state_d = StAssert;
                end
            end
            StAssert: begin
                req_d = 1'b1;
                if (ack_s_q) begin
                    req_d         = 1'b0;
                    done_d[idx_q] = 1'b1;
                    ptr_d         = (idx_q == IW'(NUM - 1)) ? '0 : idx_q + 1'b1;
                    state_d       = StDeassert;
                end
            end
            StDeassert: begin
                req_d = 1'b0;
                // Four-phase: no new request until RX has dropped ack.
                if (!ack_s_q) begin
                    state_d = StIdle;
                end
            end
            default: begin
                req_d   = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        busy_o      = (state_q != StIdle);
        grant_idx_o = idx_q;
        req_o       = req_q;
        req_data_o  = data_q;
        done_o      = done_q;
    end

endmodule
